manchester_beacon: RTL

- Parametrised Manchester frame transmitter: the next generation of the chip's single-pin heartbeat.
- Sends framed payloads on one output pin: preamble, code-violation sync, WIDTH data bits MSB first, then an idle gap.
- Payload is either an internal free-running frame counter (heartbeat mode) or a word accepted over a valid/ready handshake.
- Bit rate, Manchester convention and payload source are runtime-selectable; it sits directly behind a `uo_out` pin of the top-level wrapper.

---
 rtl/manchester_pkg.sv | 15 +
 rtl/manchester_tick.sv | 37 +++
 rtl/manchester_beacon.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/manchester_pkg.sv
// Shared types and constants for the Manchester beacon transmitter.
package manchester_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        SYNC,
        DATA,
        GAP
    } state_e;

    // Four half-bits high-high-low-low: illegal as data under either convention.
    localparam logic [3:0] SYNC_PAT = 4'b1100;

endpackage

// File: rtl/manchester_tick.sv
// Half-bit timebase: down-counter that pulses once every (div+1) clocks while running.
module manchester_tick #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             run,
    input  logic [DIV_W-1:0] load_val,
    input  logic [DIV_W-1:0] reload,
    output logic             tick
);

    logic [DIV_W-1:0] cnt_q, cnt_d;

    assign tick = run && (cnt_q == '0);

    // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = load_val;
        end else if (run) begin
            cnt_d = (cnt_q == '0) ? reload : cnt_q - 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/manchester_beacon.sv
// Framed Manchester transmitter: preamble, sync violation, MSB-first payload, idle gap.
module manchester_beacon
    import manchester_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DIV_W    = 8,
    parameter int PRE_BITS = 4,
    parameter int GAP_BITS = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             src_sel,
    input  logic             ieee,
    input  logic [DIV_W-1:0] div,
    input  logic [WIDTH-1:0] data,
    input  logic             data_valid,
    output logic             data_ready,
    output logic             tx,
    output logic             busy,
    output logic             frame_done
);

    // SYNC is counted as two bit-times, so the counter must reach at least 1.
    localparam int MAX_PW = (PRE_BITS > WIDTH) ? PRE_BITS : WIDTH;
    localparam int MAX_PWG = (MAX_PW > GAP_BITS) ? MAX_PW : GAP_BITS;
    localparam int MAXB = (MAX_PWG > 2) ? MAX_PWG : 2;
    localparam int CNT_W = $clog2(MAXB);

    state_e             state_q, state_d;
    logic               phase_q, phase_d;
    logic [CNT_W-1:0]   bit_q, bit_d;
    logic [WIDTH-1:0]   shift_q, shift_d;
    logic [WIDTH-1:0]   cnt_q, cnt_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic               ieee_q, ieee_d;
    logic               src_q, src_d;
    logic               tx_q, tx_d;
    logic               start;
    logic               tick;

    function automatic logic half_level(state_e st, logic ph, logic b0, logic msb, logic iee);
        logic [1:0] idx;
        idx = ~{b0, ph};
        case (st)
            PRE:     half_level = ph ? iee : ~iee;
            SYNC:    half_level = SYNC_PAT[idx];
            DATA:    half_level = msb ^ ph ^ iee;
            default: half_level = 1'b0;
        endcase
    endfunction

    assign busy       = (state_q != IDLE);
    assign data_ready = (state_q == IDLE) && en && src_sel;
    assign tx         = tx_q;

    manchester_tick #(.DIV_W(DIV_W)) u_tick (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (start),
        .run      (busy),
        .load_val (div),
        .reload   (div_q),
        .tick     (tick)
    );

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        cnt_d      = cnt_q;
        div_d      = div_q;
        ieee_d     = ieee_q;
        src_d      = src_q;
        tx_d       = tx_q;
        start      = 1'b0;
        frame_done = 1'b0;

        if (state_q == IDLE) begin
            if (en && (!src_sel || (data_valid && data_ready))) begin
                start   = 1'b1;
                state_d = PRE;
                phase_d = 1'b0;
                bit_d   = '0;
                div_d   = div;
                ieee_d  = ieee;
                src_d   = src_sel;
                shift_d = src_sel ? data : cnt_q;
            end
        end else if (tick) begin
            if (!phase_q) begin
                phase_d = 1'b1;
            end else begin
                phase_d = 1'b0;
                bit_d   = bit_q + 1'b1;
                case (state_q)
                    PRE: if (bit_q == CNT_W'(PRE_BITS - 1)) begin
                        state_d = SYNC;
                        bit_d   = '0;
                    end
                    SYNC: if (bit_q == CNT_W'(1)) begin
                        state_d = DATA;
                        bit_d   = '0;
                    end
                    DATA: begin
                        shift_d = shift_q << 1;
                        if (bit_q == CNT_W'(WIDTH - 1)) begin
                            state_d = GAP;
                            bit_d   = '0;
                        end
                    end
                    GAP: if (bit_q == CNT_W'(GAP_BITS - 1)) begin
                        state_d    = IDLE;
                        bit_d      = '0;
                        frame_done = 1'b1;
                        if (!src_q) cnt_d = cnt_q + 1'b1;
                    end
                    default: ;
                endcase
            end
        end

        // tx is registered, so it is loaded with the level of the half-bit about to begin.
        if (start) begin
            tx_d = half_level(PRE, 1'b0, 1'b0, 1'b0, ieee);
        end else if (tick) begin
            tx_d = half_level(state_d, phase_d, bit_d[0], shift_d[WIDTH-1], ieee_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            phase_q <= 1'b0;
            bit_q   <= '0;
            shift_q <= '0;
            cnt_q   <= '0;
            div_q   <= '0;
            ieee_q  <= 1'b0;
            src_q   <= 1'b0;
            tx_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            ieee_q  <= ieee_d;
            src_q   <= src_d;
            tx_q    <= tx_d;
        end
    end

endmodule
